// File: rtl/lzrw1_pkg.sv
// Shared types and constants for the LZRW1 item bridge.
// Items carry one control bit that selects literal or copy payloads.
package lzrw1_pkg;

    typedef enum logic [1:0] {
        StAccept   = 2'd0,
        StDrain    = 2'd1,
        StWaitIdle = 2'd2,
        StDone     = 2'd3
    } bridge_state_t;

    localparam logic CTRL_LITERAL = 1'b0;
    localparam logic CTRL_COPY    = 1'b1;

endpackage

// File: rtl/lzrw1_sync_fifo.sv
// Single-clock FIFO with registered storage, occupancy count and full/empty flags.
// Pointers carry one extra MSB so that full and empty are distinguishable.
module lzrw1_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 17
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      level_q;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                level_q <= level_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: contents are only visible through valid pointers.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/lzrw1_item_bridge.sv
// Buffers compressor items and issues them one at a time to the decompressor,
// honouring its busy backpressure and tracking end-of-stream completion.
module lzrw1_item_bridge
    import lzrw1_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_ctrl,
    input  logic                    in_last,
    input  logic                    restart,
    output logic [DATA_W-1:0]       dec_data,
    output logic                    dec_ctrl,
    output logic                    dec_valid,
    input  logic                    dec_busy,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        items_in,
    output logic [CNT_W-1:0]        items_out,
    output logic                    done,
    output logic                    err_push
);

    bridge_state_t     state_q;
    logic [DATA_W-1:0] dec_data_q;
    logic              dec_ctrl_q;
    logic              dec_valid_q;
    logic [CNT_W-1:0]  items_in_q;
    logic [CNT_W-1:0]  items_out_q;
    logic              done_q;
    logic              err_push_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_rdata;
    logic              push;
    logic              pop;

    assign in_ready = (state_q == StAccept) && !fifo_full;
    assign push     = in_valid && in_ready;
    // dec_valid_q guard keeps issues two cycles apart while busy rises.
    assign pop      = ((state_q == StAccept) || (state_q == StDrain)) &&
                      !fifo_empty && !dec_busy && !dec_valid_q;

    lzrw1_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata ({in_ctrl, in_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StAccept;
            dec_data_q  <= '0;
            dec_ctrl_q  <= 1'b0;
            dec_valid_q <= 1'b0;
            items_in_q  <= '0;
            items_out_q <= '0;
            done_q      <= 1'b0;
            err_push_q  <= 1'b0;
        end else begin
            dec_valid_q <= pop;
            if (pop) begin
                {dec_ctrl_q, dec_data_q} <= fifo_rdata;
                items_out_q              <= items_out_q + 1'b1;
            end
            if (push) begin
                items_in_q <= items_in_q + 1'b1;
            end
            if (in_valid && (state_q != StAccept)) begin
                err_push_q <= 1'b1;
            end

            case (state_q)
                StAccept: begin
                    if (push && in_last) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (fifo_empty && !pop) begin
                        state_q <= StWaitIdle;
                    end
                end
                StWaitIdle: begin
                    if (!dec_valid_q && !dec_busy) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                    end
                end
                StDone: begin
                    // Clears here override the sticky set above.
                    if (restart) begin
                        state_q     <= StAccept;
                        done_q      <= 1'b0;
                        items_in_q  <= '0;
                        items_out_q <= '0;
                        err_push_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StAccept;
                end
            endcase
        end
    end

    assign dec_data  = dec_data_q;
    assign dec_ctrl  = dec_ctrl_q;
    assign dec_valid = dec_valid_q;
    assign items_in  = items_in_q;
    assign items_out = items_out_q;
    assign done      = done_q;
    assign err_push  = err_push_q;

endmodule

// File: doc/lzrw1_item_bridge.md
# lzrw1_item_bridge

Buffered, parametrised sequencer between the LZRW1 compressor's item stream and the decompressor's single-item input port. Accepts literal/copy items with a valid/ready handshake into a DEPTH-entry FIFO, then issues them one at a time to the decompressor under its busy backpressure. Tracks end-of-stream and reports completion. Adds configurable depth and width, input backpressure, occupancy and traffic counters, and restart without reset.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- DATA_W, 16, item payload width
- CNT_W, 16, width of item counters
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_valid  in  1  compressor item present
- in_ready  out  1  bridge can accept an item this cycle
- in_data  in  DATA_W  item payload (literal byte zero-extended, or copy offset/length)
- in_ctrl  in  1  control bit: 0 literal, 1 copy
- in_last  in  1  qualifies final item of stream
- restart  in  1  single-cycle pulse; DONE → ACCEPT
- dec_data  out  DATA_W  item to decompressor
- dec_ctrl  out  1  control bit to decompressor
- dec_valid  out  1  one-cycle item strobe
- dec_busy  in  1  decompressor busy
- level  out  $clog2(DEPTH)+1  FIFO occupancy
- items_in / items_out  out  CNT_W  accepted / issued item counts
- done  out  1  stream fully delivered and decompressor idle
- err_push  out  1  sticky: in_valid seen while not in ACCEPT

## Operation
- FSM states: ACCEPT, DRAIN, WAIT_IDLE, DONE. Reset → ACCEPT.
- Push: in_valid && in_ready. in_ready = (state==ACCEPT) && (level<DEPTH). Accepted push writes {in_ctrl,in_data}, items_in += 1.
- ACCEPT → DRAIN on accepted push with in_last=1.
- Issue: state ∈ {ACCEPT, DRAIN}, level>0, dec_busy=0, dec_valid=0 → pop head; next cycle dec_valid=1 for exactly one cycle with dec_data/dec_ctrl = popped entry; items_out += 1. dec_data/dec_ctrl hold last issued value afterwards.
- Decompressor contract: raises dec_busy no later than the cycle after dec_valid; the dec_valid=0 guard covers that gap.
- DRAIN → WAIT_IDLE when level==0 and no pop pending.
- WAIT_IDLE → DONE when dec_valid=0 and dec_busy=0.
- DONE: done=1, in_ready=0. restart → ACCEPT, clears items_in, items_out, err_push. restart ignored in other states.
- Simultaneous push and pop: level unchanged, both counters step.
- Full: in_ready=0, in_valid held by producer, no data loss. Empty in ACCEPT: no issue, remain.
- in_valid=1 in DRAIN/WAIT_IDLE/DONE: not accepted, err_push set (sticky until restart/reset).
- Counters wrap modulo 2^CNT_W. FIFO pointers wrap modulo DEPTH; extra MSB separates full from empty.
- Reset mid-operation: FIFO contents discarded, state → ACCEPT.
- Reset values: in_ready=1, dec_valid=0, dec_data=0, dec_ctrl=0, level=0, items_in=0, items_out=0, done=0, err_push=0.

## Timing
- All outputs registered except in_ready, which decodes registered state/level only; no combinational in_valid→in_ready path.
- Latency, empty FIFO, idle decompressor: item accepted in cycle c → dec_valid high in cycle c+2.
- Minimum issue spacing 2 cycles (back-to-back dec_valid forbidden).
- Throughput: 1 push/cycle until full.
- done rises ≥1 cycle after the final dec_valid, when dec_busy is first seen low.

## Structure
- Package lzrw1_pkg: bridge_state_t enum, CTRL_LITERAL=1'b0, CTRL_COPY=1'b1.
- Sub-module lzrw1_sync_fifo (params DEPTH, WIDTH=DATA_W+1): registered storage, push/pop, level, full/empty. Bridge holds FSM, issue logic, counters.

## Test plan
- DEPTH=4; push 3 literals 0x0041/0x0042/0x0043, last on third, dec_busy=0 → dec_valid in cycles c+2, c+4, c+6, same order, dec_ctrl=0, done after, items_in=items_out=3.
- dec_busy held 1; push 5 items → in_ready low after 4th, level=4, 5th held; release busy → all 5 delivered, no loss.
- Mixed copy item {ctrl=1,data=0x1234} between literals, decompressor busy 3 cycles per copy → next dec_valid only after busy drops, dec_ctrl matches.
- in_valid asserted in DONE → not accepted, err_push=1; restart → ACCEPT, counters and err_push 0.
- Assert reset during DRAIN with level=2 → next cycle dec_valid=0, level=0, in_ready=1, done=0.
